// File: rtl/fft_stage3_seq.sv
// Third radix-2 DIT stage of the 16-point FFT: distance-2 butterflies (W0, -j)
// time-multiplexed over 4 cycles on 2 butterfly units, valid/ready framed.

module fft3_bfly #(
   parameter int DATA_W   = 16,
   parameter int SATURATE = 0,
   parameter int ROT      = 0
) (
   input  logic [2*DATA_W-1:0] a,
   input  logic [2*DATA_W-1:0] b,
   output logic [2*DATA_W-1:0] p,
   output logic [2*DATA_W-1:0] q
);
   localparam int W = DATA_W;

   function automatic logic [W-1:0] red(input logic [W:0] v);
      if (SATURATE != 0 && (v[W] != v[W-1]))
         red = v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
         red = v[W-1:0];
   endfunction

   function automatic logic [W:0] sx(input logic [W-1:0] v);
      sx = {v[W-1], v};
   endfunction

   logic [W-1:0] ar, ai, br, bi, sr, si, dr, di, nr;

   assign {ar, ai} = a;
   assign {br, bi} = b;
   assign sr = red(sx(ar) + sx(br));
   assign si = red(sx(ai) + sx(bi));
   assign dr = red(sx(ar) - sx(br));
   assign di = red(sx(ai) - sx(bi));
   // -j rotation negates the already-reduced difference, so it gets its own reduction
   assign nr = red({(W+1){1'b0}} - sx(dr));

   assign p = {sr, si};
   assign q = (ROT != 0) ? {di, nr} : {dr, di};
endmodule

module fft_stage3_seq #(
   parameter int DATA_W   = 16,
   parameter int SATURATE = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [32*DATA_W-1:0] stage3_data_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [32*DATA_W-1:0] stage3_data_out,
   output logic                 busy
);
   localparam int CW = 2*DATA_W;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t               state;
   logic [1:0]           cnt;
   logic [15:0][CW-1:0]  x_q, y_q;
   logic [1:0][CW-1:0]   bf_p, bf_q;

   // unit 0 pairs words b/b+2 (W0), unit 1 pairs b+1/b+3 (-j)
   for (genvar u = 0; u < 2; u++) begin : g_bf
      fft3_bfly #(.DATA_W(DATA_W), .SATURATE(SATURATE), .ROT(u)) u_bf (
         .a (x_q[{cnt, 1'b0, 1'(u)}]),
         .b (x_q[{cnt, 1'b1, 1'(u)}]),
         .p (bf_p[u]),
         .q (bf_q[u])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         x_q       <= '0;
         y_q       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  x_q      <= stage3_data_in;
                  cnt      <= 2'd0;
                  state    <= CALC;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            CALC: begin
               y_q[{cnt, 2'b00}] <= bf_p[0];
               y_q[{cnt, 2'b10}] <= bf_q[0];
               y_q[{cnt, 2'b01}] <= bf_p[1];
               y_q[{cnt, 2'b11}] <= bf_q[1];
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

   assign stage3_data_out = y_q;
endmodule

// File: doc/fft_stage3_seq.md
Name: fft_stage3_seq

Overview:
- Third radix-2 stage of the 16-point DIT FFT datapath; sits directly downstream of fft_stage2 and consumes its 16 complex outputs as one frame.
- Performs the 8 distance-2 butterflies in each group of 4 (twiddles W0 = 1 and W4 = -j).
- Time-multiplexes 2 butterfly units over 4 cycles and presents the registered 16-word result frame with a valid/ready handshake to the final stage.

Parameters:
- DATA_W, 16, width of each real/imag component (signed two's complement); complex word = 2*DATA_W bits.
- SATURATE, 0, 0 = wrap on add/sub overflow (matches fft_stage2); 1 = clamp to signed DATA_W min/max.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  stage3_data_in holds a valid frame.
- in_ready  out  1  block can accept a frame this cycle.
- stage3_data_in  in  32*DATA_W  16 complex words; word i at bits [2*DATA_W*i +: 2*DATA_W], real in upper half, imag in lower half.
- out_valid  out  1  stage3_data_out holds a completed frame.
- out_ready  in  1  downstream accepts the frame.
- stage3_data_out  out  32*DATA_W  16 result words, same packing.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (rst=0, any time, including mid-frame): state=IDLE, group counter=0, input and output frame registers=0, in_ready=0 while reset is asserted, out_valid=0, busy=0. In-flight frame is discarded.
- After release, in_ready=1 in IDLE.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge T, capture all 16 words into the input register, set cnt=0, go to CALC. in_valid is ignored in all other states.
  - CALC: one group per cycle, base b=4*cnt, cnt=0..3.
    - Unit A (W0): out[b] = x[b] + x[b+2]; out[b+2] = x[b] - x[b+2] (real and imag independently).
    - Unit B (-j): out[b+1] = x[b+1] + x[b+3]; d = x[b+1] - x[b+3]; out[b+3].re = d.im; out[b+3].im = -d.re.
    - Results are written to the output register at each edge. After the cnt=3 edge, go to DONE.
  - DONE: out_valid=1; stage3_data_out stays stable until out_ready=1. On out_valid&&out_ready, clear out_valid and go to IDLE.
- Latency and throughput:
  - Frame accepted at edge T: out_valid rises after edge T+4 (visible in the cycle following edge T+4).
  - With out_ready held high: 1 frame per 6 cycles.
- Arithmetic:
  - Sums and differences computed at DATA_W+1 bits, then reduced to DATA_W.
  - SATURATE=0: keep the low DATA_W bits (wrap).
  - SATURATE=1: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Negation of -d.re uses the same rule; with DATA_W=16 and d.re = -32768: result is -32768 (wrap) or 32767 (saturate).
- Output register content is only updated in CALC; words of the previous frame are overwritten group by group.
- stage3_data_out is undefined to consumers except while out_valid=1.
- Simultaneous events: in_valid during CALC/DONE is ignored, with no capture; the upstream must hold the frame. out_ready in IDLE/CALC has no effect.

Test Plan:
- Reset then single frame, DATA_W=16:
  - Stimulus: x[0]=(100,0), x[2]=(40,0), x[1]=(0,30), x[3]=(0,10), other words 0.
  - Required: out[0]=(140,0), out[2]=(60,0), out[1]=(0,40), out[3]=(20,0); all other words 0.
  - out_valid rises exactly 4 edges after the accepting edge.
- Full frame with word i = (i, -i):
  - Every group b: out[b]=(2b+2, -2b-2), out[b+2]=(-2,2), out[b+1]=(2b+4, -2b-4), out[b+3]=(2,2).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Required: output stable, in_ready=0, a second in_valid pulse is ignored.
  - On out_ready=1: one-cycle handshake, then IDLE with in_ready=1.
- Overflow: x[0]=(32767,-32768), x[2]=(1,1).
  - SATURATE=0: out[0]=(-32768,-32767), out[2]=(32766,32767).
  - SATURATE=1: out[0]=(32767,-32767).
- Reset asserted during cnt=2 of CALC:
  - Required: out_valid=0 immediately, output register 0, no result emitted.
  - After release: in_ready=1 and the next frame processes correctly.
- Back-to-back frames with out_ready=1 constant:
  - Required: accepts on cycles 0, 6, 12; results match the golden model for each frame.
